encoder_speed_meter: RTL and testbench

//  Front-end measurement stage feeding the AXI-lite register slave in main.

---
 rtl/encoder_speed_meter.sv | 222 ++++++++++++++++++++++
 tb/tb_encoder_speed_meter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/encoder_speed_meter.sv
// ---------------------------------------------------------------------------
// encoder_speed_meter
//   Rotary-encoder speed meter. It counts encoder pulses over a fixed gate
//   window of CLK_PERIOD clocks. At the end of each window it turns the count
//   into revolutions per minute (count * 60 / PPR) using a small sequential
//   multiply/divide engine. It also keeps a signed whole-revolution count and
//   the direction of travel.
//
//   Optional build macro: QUADRATURE_EN
//     When defined, the synchronised level of channel B at each event gives
//     the direction: 0 = forward, 1 = reverse.
//     When undefined, enc_b_i is ignored and every event counts as forward.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous, active-high reset
//   enc_a_i        encoder channel A (asynchronous)
//   enc_b_i        encoder channel B (asynchronous, QUADRATURE_EN only)
//   rpm_o          speed of the last completed window, in rev/min
//   rev_count_o    signed running revolution count (wraps mod 2^DATA_WIDTH)
//   status_o       [0] dir (1 = reverse)
//                  [1] moving
//                  [2] overrun (sticky)
//                  [3] busy
//                  all other bits 0
//   sample_valid_o one-cycle pulse when rpm_o is updated
// ---------------------------------------------------------------------------
module encoder_speed_meter #(
  parameter int CLK_PERIOD  = 10_000_000,
  parameter int PPR         = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enc_a_i,
  input  logic                  enc_b_i,
  output logic [DATA_WIDTH-1:0] rpm_o,
  output logic [DATA_WIDTH-1:0] rev_count_o,
  output logic [DATA_WIDTH-1:0] status_o,
  output logic                  sample_valid_o
);

  localparam int PW = DATA_WIDTH + 6;
  localparam int WW = (CLK_PERIOD > 1) ? $clog2(CLK_PERIOD) : 1;
  localparam int SW = (PPR > 1) ? $clog2(PPR) : 1;
  localparam int RW = $clog2(PPR) + 2;
  localparam int CW = $clog2(PW);
  localparam logic [RW-1:0] PPR_R  = RW'(PPR);
  localparam logic [WW-1:0] WIN_TC = WW'(CLK_PERIOD - 1);
  localparam logic [SW-1:0] SUB_TOP = SW'(PPR - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(PW - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] syncA_q;
  logic                   aDly_q;
  logic                   encEvent;
  logic                   dirRev;

  logic [WW-1:0]         winCnt_q;
  logic                  tc;
  logic [DATA_WIDTH-1:0] pulseCnt_q, pulseInc, pulseWithEvt;
  logic [DATA_WIDTH-1:0] snapshot_q;

  logic [PW-1:0]         prod_q;
  logic [RW-2:0]         rem_q;
  logic [RW-1:0]         remShift;
  logic                  qBit;
  logic [CW-1:0]         divCnt_q;

  logic [DATA_WIDTH-1:0] rpm_q, revCount_q;
  logic [SW-1:0]         subCnt_q;
  logic                  sampleValid_q, moving_q, overrun_q, dir_q;
  logic                  busy, doLoad, doStep, doFinish;

  // Channel A synchroniser plus one extra delayed copy for rising-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      syncA_q <= '0;
      aDly_q  <= 1'b0;
    end else begin
      syncA_q <= {syncA_q[SYNC_STAGES-2:0], enc_a_i};
      aDly_q  <= syncA_q[SYNC_STAGES-1];
    end
  end

  assign encEvent = syncA_q[SYNC_STAGES-1] & ~aDly_q;

`ifdef QUADRATURE_EN
  logic [SYNC_STAGES-1:0] syncB_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) syncB_q <= '0;
    else       syncB_q <= {syncB_q[SYNC_STAGES-2:0], enc_b_i};
  end

  assign dirRev = syncB_q[SYNC_STAGES-1];
`else
  logic unusedEncB;
  assign unusedEncB = enc_b_i;
  assign dirRev     = 1'b0;
`endif

  assign tc = (winCnt_q == WIN_TC);

  // Saturating increment; an event in the terminal cycle still belongs to the closing window.
  assign pulseInc     = (&pulseCnt_q) ? pulseCnt_q : pulseCnt_q + 1'b1;
  assign pulseWithEvt = encEvent ? pulseInc : pulseCnt_q;

  // Gate window, pulse counting, snapshot hand-off and overrun detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      winCnt_q   <= '0;
      pulseCnt_q <= '0;
      snapshot_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      winCnt_q <= tc ? '0 : winCnt_q + 1'b1;
      if (tc) begin
        pulseCnt_q <= '0;
        if (state_q == IDLE) snapshot_q <= pulseWithEvt;
        else                 overrun_q  <= 1'b1;
      end else begin
        pulseCnt_q <= pulseWithEvt;
      end
    end
  end

  // Sub-revolution position and signed whole-revolution count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      subCnt_q   <= '0;
      revCount_q <= '0;
      dir_q      <= 1'b0;
    end else if (encEvent) begin
      dir_q <= dirRev;
      if (dirRev) begin
        if (subCnt_q == '0) begin
          subCnt_q   <= SUB_TOP;
          revCount_q <= revCount_q - 1'b1;
        end else begin
          subCnt_q <= subCnt_q - 1'b1;
        end
      end else begin
        if (subCnt_q == SUB_TOP) begin
          subCnt_q   <= '0;
          revCount_q <= revCount_q + 1'b1;
        end else begin
          subCnt_q <= subCnt_q + 1'b1;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tc) state_d = MUL;
      MUL:     state_d = DIV;
      DIV:     if (divCnt_q == DIV_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    doLoad   = (state_q == MUL);
    doStep   = (state_q == DIV);
    doFinish = (state_q == DONE);
    busy     = (state_q != IDLE);
  end

  // Restoring division step. The quotient bits shift into the low end of prod_q.
  assign remShift = {rem_q, prod_q[PW-1]};
  assign qBit     = (remShift >= PPR_R);

  // Multiply by 60 as (x<<6)-(x<<2), divide by PPR, then publish the result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_q        <= '0;
      rem_q         <= '0;
      divCnt_q      <= '0;
      rpm_q         <= '0;
      moving_q      <= 1'b0;
      sampleValid_q <= 1'b0;
    end else begin
      sampleValid_q <= 1'b0;
      if (doLoad) begin
        prod_q   <= (PW'(snapshot_q) << 6) - (PW'(snapshot_q) << 2);
        rem_q    <= '0;
        divCnt_q <= '0;
      end
      if (doStep) begin
        rem_q    <= qBit ? (RW-1)'(remShift - PPR_R) : remShift[RW-2:0];
        prod_q   <= {prod_q[PW-2:0], qBit};
        divCnt_q <= divCnt_q + 1'b1;
      end
      if (doFinish) begin
        rpm_q         <= (|prod_q[PW-1:DATA_WIDTH]) ? '1 : prod_q[DATA_WIDTH-1:0];
        moving_q      <= (snapshot_q != '0);
        sampleValid_q <= 1'b1;
      end
    end
  end

  assign rpm_o          = rpm_q;
  assign rev_count_o    = revCount_q;
  assign sample_valid_o = sampleValid_q;
  assign status_o       = {{(DATA_WIDTH-4){1'b0}}, busy, overrun_q, moving_q, dir_q};

endmodule

// File: tb/tb_encoder_speed_meter.sv
// ---------------------------------------------------------------------------
// tb_encoder_speed_meter
//   Directed bench for encoder_speed_meter with CLK_PERIOD=100, PPR=10 and
//   DATA_WIDTH=32.
//   A second instance uses CLK_PERIOD=20 so that its busy period overlaps the
//   next terminal cycle.
//   The cycle counter cyc restarts at 0 on every reset, so cycle k is the
//   k-th cycle of the gate window epoch. The terminal cycles fall on
//   cyc = 99, 199, ... and results appear 41 cycles later.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_encoder_speed_meter;

  localparam int DW = 32;

`ifdef QUADRATURE_EN
  localparam logic [DW-1:0] EXP_REV_QUAD = 32'hFFFF_FFFF;
  localparam logic [DW-1:0] EXP_DIR_QUAD = 32'd1;
`else
  localparam logic [DW-1:0] EXP_REV_QUAD = 32'd1;
  localparam logic [DW-1:0] EXP_DIR_QUAD = 32'd0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          encA = 1'b0;
  logic          encB = 1'b0;
  logic [DW-1:0] rpm, revCount, status;
  logic          sampleValid;
  logic [DW-1:0] oRpm, oRev, oStatus;
  logic          oValid;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  encoder_speed_meter #(
    .CLK_PERIOD(100), .PPR(10), .DATA_WIDTH(DW), .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enc_a_i(encA), .enc_b_i(encB),
    .rpm_o(rpm), .rev_count_o(revCount), .status_o(status),
    .sample_valid_o(sampleValid)
  );

  encoder_speed_meter #(
    .CLK_PERIOD(20), .PPR(10), .DATA_WIDTH(DW), .SYNC_STAGES(2)
  ) dutOvr (
    .clk_i(clk), .rst_i(rst), .enc_a_i(encA), .enc_b_i(encB),
    .rpm_o(oRpm), .rev_count_o(oRev), .status_o(oStatus),
    .sample_valid_o(oValid)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Epoch cycle counter; mirrors the gate window position after reset.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goToCycle(input int k);
    while (cyc < k) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // n single-cycle A pulses, one every 2 cycles; each rise starts a new event.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      encA = 1'b1;
      tick();
      encA = 1'b0;
      tick();
    end
  endtask

  // Three reset cycles with A toggling, then release; cyc is 0 afterwards.
  task automatic doReset();
    rst = 1'b1;
    repeat (3) begin
      tick();
      encA = ~encA;
      checkOutput("rst_rpm", rpm, '0);
      checkOutput("rst_rev", revCount, '0);
      checkOutput("rst_status", status, '0);
      checkOutput("rst_valid", {31'b0, sampleValid}, '0);
      checkOutput("rst_ovr_rpm", oRpm, '0);
      checkOutput("rst_ovr_rev", oRev, '0);
      checkOutput("rst_ovr_valid", {31'b0, oValid}, '0);
    end
    encA = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int seen;

    // Reset behaviour
    doReset();
    checkOutput("post_rst_status", status, '0);

    // Speed: 5 pulses in window 0 -> rpm 30 at cycle 140
    goToCycle(5);
    checkOutput("ovr_clear", {31'b0, oStatus[2]}, '0);
    applyStimulus(5);
    goToCycle(50);
    checkOutput("ovr_set", {31'b0, oStatus[2]}, 32'd1);
    goToCycle(90);
    checkOutput("rev_after5", revCount, 32'd0);
    goToCycle(120);
    checkOutput("busy_div", {31'b0, status[3]}, 32'd1);
    goToCycle(139);
    checkOutput("valid_early", {31'b0, sampleValid}, '0);
    tick();
    checkOutput("valid_at41", {31'b0, sampleValid}, 32'd1);
    checkOutput("rpm_5p", rpm, 32'd30);
    checkOutput("status_moving", status, 32'h2);
    tick();
    checkOutput("valid_one_cycle", {31'b0, sampleValid}, '0);

    // Revolutions: 20 more pulses (25 total) -> rev 2; rpm 120
    goToCycle(145);
    applyStimulus(20);
    goToCycle(199);
    checkOutput("rev_after25", revCount, 32'd2);
    goToCycle(240);
    checkOutput("valid_w1", {31'b0, sampleValid}, 32'd1);
    checkOutput("rpm_20p", rpm, 32'd120);

    // Idle window 2 -> rpm 0, not moving
    goToCycle(340);
    checkOutput("valid_w2", {31'b0, sampleValid}, 32'd1);
    checkOutput("rpm_idle", rpm, 32'd0);
    checkOutput("status_idle", status, 32'd0);

    // Boundary: 4 pulses plus one whose event lands on TC at cycle 399
    goToCycle(345);
    applyStimulus(4);
    goToCycle(397);
    encA = 1'b1;
    tick();
    encA = 1'b0;
    goToCycle(440);
    checkOutput("valid_w3", {31'b0, sampleValid}, 32'd1);
    checkOutput("rpm_tc_event", rpm, 32'd30);
    goToCycle(540);
    checkOutput("valid_w4", {31'b0, sampleValid}, 32'd1);
    checkOutput("rpm_after_tc", rpm, 32'd0);
    checkOutput("rev_after30", revCount, 32'd3);
    checkOutput("ovr_sticky", {31'b0, oStatus[2]}, 32'd1);

    // Quadrature: B high during 10 A pulses from reset
    encB = 1'b1;
    doReset();
    checkOutput("ovr_rst_clear", {31'b0, oStatus[2]}, '0);
    goToCycle(5);
    applyStimulus(10);
    goToCycle(60);
    checkOutput("rev_quad", revCount, EXP_REV_QUAD);
    checkOutput("dir_quad", {31'b0, status[0]}, EXP_DIR_QUAD);
    goToCycle(140);
    checkOutput("valid_quad", {31'b0, sampleValid}, 32'd1);
    checkOutput("rpm_quad", rpm, 32'd60);

    // Abort: reset in the middle of the window-1 division
    goToCycle(145);
    applyStimulus(3);
    goToCycle(220);
    checkOutput("busy_abort", {31'b0, status[3]}, 32'd1);
    doReset();
    seen = 0;
    repeat (120) begin
      if (sampleValid) seen++;
      tick();
    end
    checkOutput("abort_no_valid", seen, 32'd0);
    checkOutput("abort_rpm", rpm, 32'd0);
    checkOutput("abort_rev", revCount, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
